// File: rtl/mem_byte_srv_pkg.sv
// Shared constants and types for the byte load/store responder:
// default geometry, MMIO addresses, address regions and fetch FSM states.
package mem_byte_srv_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam int          RAM_AW_DEF    = 17;
  localparam int          FIFO_AW_DEF   = 4;
  localparam logic [31:0] MMIO_OUT_DEF  = 32'h0003_0000;
  localparam logic [31:0] MMIO_STAT_DEF = 32'h0003_0004;

  localparam logic       ENABLE    = 1'b1;
  localparam logic       DISABLE   = 1'b0;
  localparam logic [7:0] ZERO_BYTE = 8'h00;

  // Where a byte address lands after decode.
  typedef enum logic [1:0] {
    REGION_RAM  = 2'd0,
    REGION_STAT = 2'd1,
    REGION_OUT  = 2'd2,
    REGION_OOB  = 2'd3
  } region_e;

  // Fetch port: accept a request, then present the byte for one cycle.
  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_RESP = 1'b1
  } fetch_state_e;

  // Status byte as seen at MMIO_STAT: bit1 = FIFO full, bit0 = FIFO empty.
  function automatic logic [7:0] status_byte(input logic full, input logic empty);
    return {6'b000000, full, empty};
  endfunction

endpackage

// File: rtl/mem_byte_srv_if.sv
// Bus bundle between the MEM stage / fetch unit / host and the byte responder.
// The responder uses the slave view; whoever drives requests uses the master view.
interface mem_byte_srv_if
  import mem_byte_srv_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  // data port (loads and stores)
  logic              le;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0]        l_data;
  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [7:0]        if_rdata;
  // output byte stream towards the host / UART
  logic              io_out_valid;
  logic [7:0]        io_out_data;
  logic              io_out_ready;
  // sticky error flags
  logic              err_oob;
  logic              err_ovf;
  logic              err_coll;

  modport slave (
    input  le, l_addr, we, w_addr, w_data, if_req, if_addr, io_out_ready,
    output l_data, if_valid, if_rdata, io_out_valid, io_out_data,
           err_oob, err_ovf, err_coll
  );

  modport master (
    output le, l_addr, we, w_addr, w_data, if_req, if_addr, io_out_ready,
    input  l_data, if_valid, if_rdata, io_out_valid, io_out_data,
           err_oob, err_ovf, err_coll
  );
endinterface

// File: rtl/mem_byte_srv_byte_fifo.sv
// Byte FIFO holding MMIO output bytes until the host pops them.
// Occupancy is tracked with an explicit count so full/empty never alias;
// a push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo
  import mem_byte_srv_pkg::*;
#(
  parameter int AW = FIFO_AW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int            DEPTH      = 1 << AW;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty = (count_r == {(AW + 1){1'b0}});
  assign full  = (count_r == FULL_COUNT);
  assign dout  = empty ? ZERO_BYTE : mem_r[rd_ptr_r];

  // Qualify requests against occupancy; pop first so push-when-full can ride on it.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at 2**AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Byte storage; contents are don't-care once popped, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/mem_byte_srv.sv
// Byte-wide load/store responder for the MEM stage with a lower-priority
// instruction-fetch port, a single-port byte RAM, and an MMIO byte output FIFO.
// The data port is never stalled; fetches slip in only on cycles where the
// data port leaves the RAM idle, so the RAM sees at most one access per cycle.
module mem_byte_srv
  import mem_byte_srv_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                RAM_AW    = RAM_AW_DEF,
  parameter logic [ADDR_W-1:0] MMIO_OUT  = ADDR_W'(MMIO_OUT_DEF),
  parameter logic [ADDR_W-1:0] MMIO_STAT = ADDR_W'(MMIO_STAT_DEF),
  parameter int                FIFO_AW   = FIFO_AW_DEF
) (
  input logic            clk,
  input logic            rst,
  mem_byte_srv_if.slave  bus
);
  localparam int RAM_BYTES = 1 << RAM_AW;

  // Map a byte address to the block that owns it.
  function automatic region_e decode(input logic [ADDR_W-1:0] a);
    if (a == MMIO_STAT) begin
      return REGION_STAT;
    end else if (a == MMIO_OUT) begin
      return REGION_OUT;
    end else if ((a >> RAM_AW) == {ADDR_W{1'b0}}) begin
      return REGION_RAM;
    end else begin
      return REGION_OOB;
    end
  endfunction

  logic [7:0]        ram_r [RAM_BYTES];
  logic [RAM_AW-1:0] ram_addr_s;
  logic [7:0]        ram_rd_s;
  logic              ram_we_s;

  region_e           l_reg_s;
  region_e           w_reg_s;
  region_e           f_reg_s;

  fetch_state_e      state_r;
  fetch_state_e      state_next_s;
  logic              fetch_accept_s;

  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic [7:0]        fifo_dout_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;

  logic              oob_hit_s;
  logic              ovf_hit_s;
  logic              coll_hit_s;

  logic [7:0]        l_data_r;
  logic [7:0]        if_rdata_r;
  logic              err_oob_r;
  logic              err_ovf_r;
  logic              err_coll_r;

  // Decode all three request addresses every cycle.
  always_comb begin
    l_reg_s = decode(bus.l_addr);
    w_reg_s = decode(bus.w_addr);
    f_reg_s = decode(bus.if_addr);
  end

  // Single RAM address: store wins, then load, otherwise the fetch address.
  always_comb begin
    ram_we_s = bus.we & ~rst & (w_reg_s == REGION_RAM);
    if (bus.we) begin
      ram_addr_s = bus.w_addr[RAM_AW-1:0];
    end else if (bus.le) begin
      ram_addr_s = bus.l_addr[RAM_AW-1:0];
    end else begin
      ram_addr_s = bus.if_addr[RAM_AW-1:0];
    end
    ram_rd_s = ram_r[ram_addr_s];
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_r[ram_addr_s] <= bus.w_data;
    end
  end

  // FIFO control and error detection for the current cycle.
  always_comb begin
    fifo_pop_s  = bus.io_out_ready & ~fifo_empty_s;
    fifo_push_s = bus.we & (w_reg_s == REGION_OUT) & (~fifo_full_s | fifo_pop_s);
    ovf_hit_s   = bus.we & (w_reg_s == REGION_OUT) & fifo_full_s & ~fifo_pop_s;
    coll_hit_s  = bus.le & bus.we;
    oob_hit_s   = (bus.le & (l_reg_s == REGION_OOB))
                | (bus.we & ((w_reg_s == REGION_OOB) | (w_reg_s == REGION_STAT)))
                | (fetch_accept_s & (f_reg_s != REGION_RAM));
  end

  // Fetch FSM next state: accept only when the data port leaves the RAM free.
  always_comb begin
    state_next_s   = state_r;
    fetch_accept_s = DISABLE;
    case (state_r)
      FETCH_IDLE: begin
        if (bus.if_req & ~bus.le & ~bus.we) begin
          fetch_accept_s = ENABLE;
          state_next_s   = FETCH_RESP;
        end else begin
          state_next_s   = FETCH_IDLE;
        end
      end
      FETCH_RESP: state_next_s = FETCH_IDLE;
      default:    state_next_s = FETCH_IDLE;
    endcase
  end

  // Fetch FSM state register; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Fetched byte, captured in the accept cycle and shown during RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_r <= ZERO_BYTE;
    end else if (fetch_accept_s) begin
      if_rdata_r <= (f_reg_s == REGION_RAM) ? ram_rd_s : ZERO_BYTE;
    end else begin
      if_rdata_r <= if_rdata_r;
    end
  end

  // Load data: one-cycle latency, holds when idle, zero on load/store collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      l_data_r <= ZERO_BYTE;
    end else if (bus.le) begin
      if (bus.we) begin
        l_data_r <= ZERO_BYTE;
      end else begin
        case (l_reg_s)
          REGION_RAM:  l_data_r <= ram_rd_s;
          REGION_STAT: l_data_r <= status_byte(fifo_full_s, fifo_empty_s);
          default:     l_data_r <= ZERO_BYTE;
        endcase
      end
    end else begin
      l_data_r <= l_data_r;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob_r  <= DISABLE;
      err_ovf_r  <= DISABLE;
      err_coll_r <= DISABLE;
    end else begin
      err_oob_r  <= err_oob_r  | oob_hit_s;
      err_ovf_r  <= err_ovf_r  | ovf_hit_s;
      err_coll_r <= err_coll_r | coll_hit_s;
    end
  end

  byte_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push_s),
    .din   (bus.w_data),
    .pop   (fifo_pop_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign bus.l_data       = l_data_r;
  assign bus.if_valid     = (state_r == FETCH_RESP);
  assign bus.if_rdata     = if_rdata_r;
  assign bus.io_out_valid = ~fifo_empty_s;
  assign bus.io_out_data  = fifo_dout_s;
  assign bus.err_oob      = err_oob_r;
  assign bus.err_ovf      = err_ovf_r;
  assign bus.err_coll     = err_coll_r;

endmodule

// File: tb/tb_mem_byte_srv.sv
// Self-checking bench for mem_byte_srv: a byte-RAM model and a FIFO model
// supply expected values, which are queued when stimulus is driven and
// popped when the DUT responds.
module tb_mem_byte_srv;

  localparam logic [31:0] OUT_A  = 32'h0003_0000;
  localparam logic [31:0] STAT_A = 32'h0003_0004;
  localparam logic [31:0] RAM_LIM = 32'h0002_0000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] ram_m [int];
  logic [7:0] fifo_m [$];
  logic [7:0] rd_q [$];
  logic [7:0] fetch_q [$];
  logic [7:0] pre_bytes [4];

  mem_byte_srv_if #(.ADDR_W(32)) bus ();

  mem_byte_srv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.le = 1'b0; bus.l_addr = 32'h0; bus.we = 1'b0; bus.w_addr = 32'h0;
    bus.w_data = 8'h00; bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.io_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    fifo_m.delete();
  endtask

  function automatic logic [7:0] exp_read(input logic [31:0] a);
    if (a < RAM_LIM) return ram_m.exists(int'(a)) ? ram_m[int'(a)] : 8'h00;
    else if (a == STAT_A) return {6'b000000, fifo_m.size() == 16, fifo_m.size() == 0};
    else return 8'h00;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [7:0] d);
    bus.we = 1'b1; bus.w_addr = a; bus.w_data = d;
    if (a < RAM_LIM) ram_m[int'(a)] = d;
    else if (a == OUT_A && fifo_m.size() < 16) fifo_m.push_back(d);
    step();
    bus.we = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    bus.le = 1'b1; bus.l_addr = a;
    rd_q.push_back(exp_read(a));
    step();
    bus.le = 1'b0;
    chk(tag, bus.l_data, rd_q.pop_front());
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a, input int exp_wait);
    int waited = 0;
    logic got = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = a;
    fetch_q.push_back(exp_read(a));
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      waited++;
      got = bus.if_valid;
    end
    bus.if_req = 1'b0;
    chk({tag, "_lat"}, waited, exp_wait);
    chk({tag, "_data"}, bus.if_rdata, fetch_q.pop_front());
  endtask

  task automatic drain(input string tag, input int exp_n);
    int n = 0;
    bus.io_out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (!bus.io_out_valid) break;
      if (fifo_m.size() == 0) begin
        chk({tag, "_extra"}, bus.io_out_valid, 1'b0);
        break;
      end
      chk({tag, "_pop"}, bus.io_out_data, fifo_m.pop_front());
      n++;
      step();
    end
    bus.io_out_ready = 1'b0;
    chk({tag, "_count"}, n, exp_n);
    chk({tag, "_empty"}, bus.io_out_valid, 1'b0);
  endtask

  initial begin
    int waited;
    int pulses;
    logic got;
    idle_bus();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    chk("rst_l_data", bus.l_data, 8'h00);
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_if_rdata", bus.if_rdata, 8'h00);
    chk("rst_io_valid", bus.io_out_valid, 1'b0);
    chk("rst_io_data", bus.io_out_data, 8'h00);
    chk("rst_err_oob", bus.err_oob, 1'b0);
    chk("rst_err_ovf", bus.err_ovf, 1'b0);
    chk("rst_err_coll", bus.err_coll, 1'b0);

    // 1: write then read back-to-back
    do_write(32'h100, 8'hA5);
    do_read("t1_rd", 32'h100);

    // 2: preload, then reads at 2-cycle spacing
    pre_bytes[0] = 8'h78; pre_bytes[1] = 8'h56; pre_bytes[2] = 8'h34; pre_bytes[3] = 8'h12;
    for (int i = 0; i < 4; i++) do_write(32'h200 + i, pre_bytes[i]);
    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("t2_rd%0d", i), 32'h200 + i);
      step();
    end

    // 3: fetch held off by data-port reads
    do_write(32'h0, 8'h3C);
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    fetch_q.push_back(exp_read(32'h0));
    for (int k = 0; k < 3; k++) begin
      do_read($sformatf("t3_rd%0d", k), 32'h100);
      bus.le = 1'b1;
      chk($sformatf("t3_blocked%0d", k), bus.if_valid, 1'b0);
    end
    bus.le = 1'b0;
    waited = 0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      waited++;
      got = bus.if_valid;
    end
    bus.if_req = 1'b0;
    chk("t3_lat", waited, 1);
    chk("t3_data", bus.if_rdata, fetch_q.pop_front());
    step();
    chk("t3_pulse", bus.if_valid, 1'b0);
    chk("t3_l_hold", bus.l_data, 8'hA5);
    // throughput: back-to-back fetches are spaced two cycles
    do_fetch("t3_f1", 32'h200, 1);
    do_fetch("t3_f2", 32'h203, 2);

    // 4: overflow the output FIFO, read status, drain
    for (int i = 0; i < 17; i++) do_write(OUT_A, 8'(i));
    chk("t4_ovf", bus.err_ovf, 1'b1);
    chk("t4_valid", bus.io_out_valid, 1'b1);
    chk("t4_head", bus.io_out_data, 8'h00);
    do_read("t4_stat_full", STAT_A);
    drain("t4", 16);
    do_read("t4_stat_empty", STAT_A);

    // 5: push and pop together while full
    do_reset();
    for (int i = 0; i < 16; i++) do_write(OUT_A, 8'h40 + 8'(i));
    bus.io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.we = 1'b1; bus.w_addr = OUT_A; bus.w_data = 8'h50 + 8'(i);
      chk($sformatf("t5_head%0d", i), bus.io_out_data, fifo_m.pop_front());
      fifo_m.push_back(8'h50 + 8'(i));
      step();
    end
    bus.we = 1'b0; bus.io_out_ready = 1'b0;
    chk("t5_ovf", bus.err_ovf, 1'b0);
    do_read("t5_stat", STAT_A);
    drain("t5", 16);

    // 6: out-of-range, collision, status write, reset while a fetch waits
    do_reset();
    do_read("t6_oob_rd", 32'h0004_0000);
    chk("t6_oob", bus.err_oob, 1'b1);
    chk("t6_no_coll", bus.err_coll, 1'b0);
    bus.le = 1'b1; bus.l_addr = 32'h100;
    bus.we = 1'b1; bus.w_addr = 32'h101; bus.w_data = 8'h77;
    ram_m[32'h101] = 8'h77;
    rd_q.push_back(8'h00);
    step();
    bus.le = 1'b0; bus.we = 1'b0;
    chk("t6_coll_rd", bus.l_data, rd_q.pop_front());
    chk("t6_coll", bus.err_coll, 1'b1);
    do_read("t6_coll_wr", 32'h101);
    do_reset();
    do_write(STAT_A, 8'h01);
    chk("t6_stat_wr_oob", bus.err_oob, 1'b1);
    do_fetch("t6_f_oob", 32'h0005_0000, 1);
    bus.we = 1'b1; bus.w_addr = OUT_A; bus.w_data = 8'h99;
    bus.le = 1'b1; bus.l_addr = 32'h100;
    step();
    bus.we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    pulses = 0;
    for (int c = 0; c < 2; c++) begin
      step();
      pulses += int'(bus.if_valid);
    end
    rst = 1'b1;
    step();
    pulses += int'(bus.if_valid);
    rst = 1'b0; bus.if_req = 1'b0; bus.le = 1'b0;
    fifo_m.delete();
    for (int c = 0; c < 5; c++) begin
      step();
      pulses += int'(bus.if_valid);
    end
    chk("t6_rst_pulses", pulses, 0);
    chk("t6_rst_oob", bus.err_oob, 1'b0);
    chk("t6_rst_coll", bus.err_coll, 1'b0);
    chk("t6_rst_ovf", bus.err_ovf, 1'b0);
    chk("t6_rst_fifo", bus.io_out_valid, 1'b0);
    do_read("t6_ram_kept", 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
